// File: rtl/seq_serial_gen_pkg.sv
// Shared types and helpers for the serial pattern generator.
// Optional macro SEQ_GEN_PARITY_EN adds the PARITY state encoding.
package seq_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_REP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
`ifdef SEQ_GEN_PARITY_EN
        , ST_PARITY = 2'd3
`endif
    } state_t;

    // A requested length of 0, or one larger than the pattern register, means "full width".
    function automatic int clamp_len(input int len, input int width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/seq_serial_gen_if.sv
// Load handshake and serial output stream of the pattern generator.
// slave: generator side; master: requester/sink side.
interface seq_serial_gen_if
    import seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = $clog2(WIDTH + 1),
    parameter int REP_W = DEF_REP_W
) ();

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [LEN_W-1:0] load_len;
    logic [REP_W-1:0] load_rep;
    logic             out_ready;
    logic             out_bit;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport slave (
        input  load_valid, load_data, load_len, load_rep, out_ready,
        output load_ready, out_bit, out_valid, busy, done
    );

    modport master (
        output load_valid, load_data, load_len, load_rep, out_ready,
        input  load_ready, out_bit, out_valid, busy, done
    );

endinterface

// File: rtl/seq_serial_gen.sv
// Serial pattern transmitter: loads a 1..WIDTH bit pattern plus repeat count,
// then streams it MSB-first with valid/ready flow control. All outputs are registered.
// Optional macro SEQ_GEN_PARITY_EN appends an even-parity bit after every pass.
module seq_serial_gen
    import seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = $clog2(WIDTH + 1),
    parameter int REP_W = DEF_REP_W
) (
    input  logic            clk,
    input  logic            reset_n,
    seq_serial_gen_if.slave bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             out_bit_q, out_bit_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load_ready_q, load_ready_d;

    logic [LEN_W-1:0] len_c;
    logic [WIDTH-1:0] len_mask;
    logic [WIDTH-1:0] pat_shifted;
    logic             end_pass;

    assign len_c = LEN_W'(clamp_len(int'(bus.load_len), WIDTH));

    // Unused high pattern bits are cleared at load so parity only covers the live bits.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
        assign len_mask[gi] = (LEN_W'(gi) < len_c);
    end

    // Next-state, datapath and output decode; outputs derive from the next state so they register cleanly.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        idx_d       = idx_q;
        rep_d       = rep_q;
        end_pass    = 1'b0;
        out_bit_d   = 1'b0;
        pat_shifted = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.load_valid) begin
                    pat_d   = bus.load_data & len_mask;
                    len_d   = len_c;
                    rep_d   = bus.load_rep;
                    idx_d   = len_c - LEN_W'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.out_ready) begin
                    if (idx_q != '0) begin
                        idx_d = idx_q - LEN_W'(1);
                    end else begin
`ifdef SEQ_GEN_PARITY_EN
                        state_d = ST_PARITY;
`else
                        end_pass = 1'b1;
`endif
                    end
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            ST_PARITY: begin
                if (bus.out_ready) begin
                    end_pass = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pass boundary: restart the pattern without a bubble, or finish.
        if (end_pass) begin
            if (rep_q != '0) begin
                rep_d   = rep_q - REP_W'(1);
                idx_d   = len_q - LEN_W'(1);
                state_d = ST_SHIFT;
            end else begin
                state_d = ST_DONE;
            end
        end

        pat_shifted = pat_d >> idx_d;
        if (state_d == ST_SHIFT) begin
            out_bit_d = pat_shifted[0];
        end
`ifdef SEQ_GEN_PARITY_EN
        if (state_d == ST_PARITY) begin
            out_bit_d = ^pat_d;
        end
        out_valid_d  = (state_d == ST_SHIFT) || (state_d == ST_PARITY);
`else
        out_valid_d  = (state_d == ST_SHIFT);
`endif
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
        load_ready_d = (state_d == ST_IDLE);
    end

    // State and registered outputs; reset aborts any stream with no done pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pat_q        <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            rep_q        <= '0;
            out_bit_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            rep_q        <= rep_d;
            out_bit_q    <= out_bit_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign bus.out_bit    = out_bit_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.load_ready = load_ready_q;

endmodule

// File: tb/tb_seq_serial_gen.sv
// Self-checking bench for seq_serial_gen: directed cases then randomized loads,
// checked cycle by cycle against a queue of expected stream bits.
// Honours SEQ_GEN_PARITY_EN when the design is built with it.
module tb_seq_serial_gen;

    localparam int WIDTH = 8;
    localparam int LEN_W = $clog2(WIDTH + 1);
    localparam int REP_W = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    seq_serial_gen_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W)) bus ();

    seq_serial_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_load_ready"}, 32'(bus.load_ready), 32'd1);
        check({tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
        check({tag, "_out_bit"},    32'(bus.out_bit),    32'd0);
        check({tag, "_busy"},       32'(bus.busy),       32'd0);
        check({tag, "_done"},       32'(bus.done),       32'd0);
    endtask

    // Reference: the bit sequence a load should produce, built straight from the rules.
    task automatic build_expected(input logic [WIDTH-1:0] data, input int len, input int rep,
                                  output bit q[$]);
        int eff;
        int ones;
        q = {};
        eff = (len == 0 || len > WIDTH) ? WIDTH : len;
        ones = 0;
        for (int i = 0; i < eff; i++) ones += int'(data[i]);
        for (int p = 0; p <= rep; p++) begin
            for (int i = eff - 1; i >= 0; i--) q.push_back(data[i]);
`ifdef SEQ_GEN_PARITY_EN
            q.push_back(bit'(ones % 2));
`endif
        end
    endtask

    // mode 0: out_ready always 1; 1: random; 2: stall in cycles N+2..N+4.
    // abort_after >= 0: pull reset while that many bits have been accepted.
    task automatic run_pat(input string tag, input logic [WIDTH-1:0] data, input int len,
                           input int rep, input int mode, input int abort_after);
        bit q[$];
        int c;
        int popped;
        logic rdy;
        build_expected(data, len, rep, q);
        $display("load %s: data=%02h len=%0d rep=%0d bits=%0d mode=%0d", tag, data, len, rep,
                 q.size(), mode);
        check({tag, "_pre_ready"}, 32'(bus.load_ready), 32'd1);
        bus.load_valid = 1'b1;
        bus.load_data  = data;
        bus.load_len   = LEN_W'(len);
        bus.load_rep   = REP_W'(rep);
        bus.out_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.load_valid = 1'b0;
        c = 1;
        popped = 0;
        while (q.size() > 0) begin
            check({tag, "_budget"}, 32'(c <= 500), 32'd1);
            if (c > 500) break;
            check({tag, "_valid"},      32'(bus.out_valid),  32'd1);
            check({tag, "_bit"},        32'(bus.out_bit),    32'(q[0]));
            check({tag, "_busy"},       32'(bus.busy),       32'd1);
            check({tag, "_load_ready"}, 32'(bus.load_ready), 32'd0);
            check({tag, "_done_early"}, 32'(bus.done),       32'd0);
            case (mode)
                1:       rdy = ($urandom_range(0, 3) != 0);
                2:       rdy = !(c >= 2 && c <= 4);
                default: rdy = 1'b1;
            endcase
            bus.out_ready  = rdy;
            // Loads presented while busy must be ignored.
            bus.load_valid = 1'($urandom_range(0, 1));
            bus.load_data  = WIDTH'($urandom);
            bus.load_len   = LEN_W'($urandom);
            bus.load_rep   = REP_W'($urandom);
            if (abort_after >= 0 && popped == abort_after) reset_n = 1'b0;
            @(posedge clk);
            @(negedge clk);
            c++;
            if (!reset_n) begin
                check_idle({tag, "_abort"});
                reset_n = 1'b1;
                bus.load_valid = 1'b0;
                bus.out_ready  = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check_idle({tag, "_after_abort"});
                return;
            end
            if (rdy) begin
                void'(q.pop_front());
                popped++;
            end
        end
        check({tag, "_done"},            32'(bus.done),       32'd1);
        check({tag, "_done_valid"},      32'(bus.out_valid),  32'd0);
        check({tag, "_done_busy"},       32'(bus.busy),       32'd1);
        check({tag, "_done_load_ready"}, 32'(bus.load_ready), 32'd0);
        bus.load_valid = 1'b1;  // must be ignored in DONE
        bus.out_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.load_valid = 1'b0;
        check_idle({tag, "_end"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hFF;
        bus.load_len   = LEN_W'(3);
        bus.load_rep   = '0;
        bus.out_ready  = 1'b1;
        reset_n        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("reset: held 3 cycles with load_valid=1");
        check_idle("reset");
        bus.load_valid = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("post_reset");

        run_pat("c2_001",      8'b0000_0001, 3, 0, 0, -1);
        run_pat("c3_rep2",     8'b1010_1001, 3, 2, 0, -1);
        run_pat("c4_stall",    8'b0000_0001, 3, 0, 2, -1);
        run_pat("c5_abort",    8'hA5,        0, 0, 0, 4);
        run_pat("len0_full",   8'hA5,        0, 0, 0, -1);
        run_pat("len1",        8'hFE,        1, 3, 0, -1);
        run_pat("len_over",    8'h3C,        12, 1, 1, -1);
`ifdef SEQ_GEN_PARITY_EN
        run_pat("c6_parity",   8'b0000_0011, 3, 1, 0, -1);
`endif
        for (int t = 0; t < 40; t++) begin
            run_pat("rand", WIDTH'($urandom), $urandom_range(0, 15), $urandom_range(0, 3), 1, -1);
        end
        run_pat("rand_abort", WIDTH'($urandom), 8, 2, 1, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
